// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared types and default widths for the data memory arbiter.
//   owner_e        : identifies the port that owns an access (core / loader)
//   DMA_ADDR_WIDTH : default byte address width
//   DMA_DATA_WIDTH : default data word width (multiple of 8)
// -----------------------------------------------------------------------------
package data_mem_arb_pkg;

    typedef enum logic {
        OWNER_CORE   = 1'b0,
        OWNER_LOADER = 1'b1
    } owner_e;

    localparam int unsigned DMA_ADDR_WIDTH = 32;
    localparam int unsigned DMA_DATA_WIDTH = 32;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles both requester ports and the RAM port of the data memory arbiter.
//   m0_* : core load/store port      m1_* : loader/debug port (+ m1_lock)
//   mem_*: single-port synchronous data RAM
// Modports:
//   slave  : arbiter view (requests and mem_rdata in; grants, responses and
//            RAM controls out)
//   master : requester/RAM view (the reverse)
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = data_mem_arb_pkg::DMA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = data_mem_arb_pkg::DMA_DATA_WIDTH
);

    logic                    m0_req,    m1_req;
    logic                    m0_we,     m1_we;
    logic [ADDR_WIDTH-1:0]   m0_addr,   m1_addr;
    logic [DATA_WIDTH-1:0]   m0_wdata,  m1_wdata;
    logic [DATA_WIDTH/8-1:0] m0_wstrb,  m1_wstrb;
    logic                    m1_lock;
    logic                    m0_gnt,    m1_gnt;
    logic                    m0_rvalid, m1_rvalid;
    logic [DATA_WIDTH-1:0]   m0_rdata,  m1_rdata;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_wstrb, m1_wstrb, m1_lock, mem_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_wstrb, m1_wstrb, m1_lock, mem_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/data_mem_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way grant logic with loader bus lock.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : requests (bit 0 = core, bit 1 = loader)
//   lock_i     : loader asks to keep ownership after its current grant
//   gnt_o[1:0] : combinational one-hot (or zero) grant, forced 0 in reset
// Build option DATA_MEM_ARB_FIXED_PRIO_EN: ties always go to the core and the
// last-owner register is removed; lock behaviour is unchanged.
// -----------------------------------------------------------------------------
module arb_rr2
    import data_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);

    logic locked_q, locked_d;

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
    owner_e last_owner_q, last_owner_d;
`endif

    always_comb begin
        gnt_o = '0;
        if (!rst_n) begin
            gnt_o = '0;
        end else if (locked_q) begin
            gnt_o[1] = req_i[1];
        end else if (req_i == 2'b11) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
            gnt_o = 2'b01;
`else
            // tie goes to the port that did not win last
            gnt_o = (last_owner_q == OWNER_LOADER) ? 2'b01 : 2'b10;
`endif
        end else begin
            gnt_o = req_i;
        end
    end

    // Lock follows m1_lock on every loader grant; a locked bus with no loader
    // request is released so an abandoned lock cannot starve the core.
    always_comb begin
        locked_d = locked_q;
        if (gnt_o[1]) begin
            locked_d = lock_i;
        end else if (locked_q && !req_i[1]) begin
            locked_d = 1'b0;
        end
    end

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt_o[0]) begin
            last_owner_d = OWNER_CORE;
        end else if (gnt_o[1]) begin
            last_owner_d = OWNER_LOADER;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q     <= 1'b0;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
            last_owner_q <= OWNER_LOADER;
`endif
        end else begin
            locked_q     <= locked_d;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port synchronous data RAM between the core load/store port
// (port 0) and the program loader/debug port (port 1).
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : data_mem_arbiter_if.slave (both requester ports + RAM port)
// Grants are combinational (arb_rr2); the granted port drives the RAM, and a
// read grant returns mem_rdata to its owner one cycle later.
// Build option DATA_MEM_ARB_FIXED_PRIO_EN: fixed priority (core wins ties)
// instead of round-robin.
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);

    logic [1:0] gnt;
    logic       rd_pending_q, rd_pending_d;
    owner_e     rd_owner_q,   rd_owner_d;
    logic       m0_rvalid,    m1_rvalid;

    arb_rr2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req_i ({bus.m1_req, bus.m0_req}),
        .lock_i(bus.m1_lock),
        .gnt_o (gnt)
    );

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    always_comb begin
        bus.mem_en    = gnt[0] | gnt[1];
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (gnt[0]) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            bus.mem_wstrb = bus.m0_wstrb;
        end else if (gnt[1]) begin
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_wstrb = bus.m1_wstrb;
        end
    end

    always_comb begin
        rd_pending_d = (gnt[0] & ~bus.m0_we) | (gnt[1] & ~bus.m1_we);
        rd_owner_d   = gnt[1] ? OWNER_LOADER : OWNER_CORE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWNER_CORE;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0_rvalid     = rd_pending_q && (rd_owner_q == OWNER_CORE);
    assign m1_rvalid     = rd_pending_q && (rd_owner_q == OWNER_LOADER);
    assign bus.m0_rvalid = m0_rvalid;
    assign bus.m1_rvalid = m1_rvalid;
    assign bus.m0_rdata  = m0_rvalid ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = m1_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Self-checking bench for data_mem_arbiter. Directed scenarios pin literal
// expectations; a randomized phase is checked every cycle against a
// behavioural reference model. Honours DATA_MEM_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_mem_arbiter dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: who won last (0/1), lock flag, pending read owner
    int m_last   = 1;
    bit m_locked = 1'b0;
    int m_pend   = -1;
    bit exp_g0   = 1'b0;
    bit exp_g1   = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        bit          g0, g1, rv0, rv1, ewe;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        if (!reset) begin
            check("rst_m0_gnt",    64'(bus.m0_gnt),    64'(0));
            check("rst_m1_gnt",    64'(bus.m1_gnt),    64'(0));
            check("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'(0));
            check("rst_m1_rvalid", 64'(bus.m1_rvalid), 64'(0));
            check("rst_m0_rdata",  64'(bus.m0_rdata),  64'(0));
            check("rst_m1_rdata",  64'(bus.m1_rdata),  64'(0));
            check("rst_mem_en",    64'(bus.mem_en),    64'(0));
            m_last   = 1;
            m_locked = 1'b0;
            m_pend   = -1;
            exp_g0   = 1'b0;
            exp_g1   = 1'b0;
        end else begin
            if (m_locked) begin
                g0 = 1'b0;
                g1 = bus.m1_req;
            end else if (bus.m0_req && bus.m1_req) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
                g0 = 1'b1;
`else
                g0 = (m_last == 1);
`endif
                g1 = !g0;
            end else begin
                g0 = bus.m0_req;
                g1 = bus.m1_req;
            end
            rv0 = (m_pend == 0);
            rv1 = (m_pend == 1);
            ewe = 1'b0; ea = '0; ed = '0; es = '0;
            if (g0) begin
                ewe = bus.m0_we; ea = bus.m0_addr; ed = bus.m0_wdata; es = bus.m0_wstrb;
            end else if (g1) begin
                ewe = bus.m1_we; ea = bus.m1_addr; ed = bus.m1_wdata; es = bus.m1_wstrb;
            end
            check("m0_gnt",    64'(bus.m0_gnt),    64'(g0));
            check("m1_gnt",    64'(bus.m1_gnt),    64'(g1));
            check("mem_en",    64'(bus.mem_en),    64'(g0 | g1));
            check("mem_we",    64'(bus.mem_we),    64'(ewe));
            check("mem_addr",  64'(bus.mem_addr),  64'(ea));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(ed));
            check("mem_wstrb", 64'(bus.mem_wstrb), 64'(es));
            check("m0_rvalid", 64'(bus.m0_rvalid), 64'(rv0));
            check("m1_rvalid", 64'(bus.m1_rvalid), 64'(rv1));
            check("m0_rdata",  64'(bus.m0_rdata),  rv0 ? 64'(bus.mem_rdata) : 64'(0));
            check("m1_rdata",  64'(bus.m1_rdata),  rv1 ? 64'(bus.mem_rdata) : 64'(0));
            // advance the model to the state after the coming edge
            if (g0) m_last = 0;
            if (g1) m_last = 1;
            if (g1) m_locked = bus.m1_lock;
            else if (m_locked && !bus.m1_req) m_locked = 1'b0;
            if (g0 && !bus.m0_we)      m_pend = 0;
            else if (g1 && !bus.m1_we) m_pend = 1;
            else                       m_pend = -1;
            exp_g0 = g0;
            exp_g1 = g1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit req, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
    endtask

    task automatic set1(input bit req, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit lk);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
        bus.m1_lock = lk;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [3:0] tie_m0;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
        tie_m0 = 4'b1111;
`else
        tie_m0 = 4'b0101;   // bit i = expected m0_gnt in tie cycle i
`endif
        reset = 1'b0;
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0, 0);
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        bus.m0_req = 1'b1;
        @(negedge clk);
        check("gnt_during_reset", 64'(bus.m0_gnt), 64'(0));

        // both ports read continuously right after reset
        step();
        reset = 1'b1;
        set0(1, 0, 32'h10, '0, '0);
        set1(1, 0, 32'h20, '0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step();
                bus.mem_rdata = 32'h100 + 32'(i);
            end
            @(negedge clk);
            check($sformatf("tie_m0_gnt%0d", i), 64'(bus.m0_gnt), 64'(tie_m0[i]));
        end

        // port 0 write 84 <- 71
        step();
        set1(0, 0, '0, '0, '0, 0);
        set0(1, 1, 32'd84, 32'd71, 4'hF);
        @(negedge clk);
        check("wr_m0_gnt",    64'(bus.m0_gnt),    64'(1));
        check("wr_mem_we",    64'(bus.mem_we),    64'(1));
        check("wr_mem_addr",  64'(bus.mem_addr),  64'(84));
        check("wr_mem_wdata", 64'(bus.mem_wdata), 64'(71));
        check("wr_mem_wstrb", 64'(bus.mem_wstrb), 64'(15));
        step();
        set0(0, 0, '0, '0, '0);
        @(negedge clk);
        check("wr_no_rvalid", 64'(bus.m0_rvalid), 64'(0));

        // port 0 read 84, RAM returns 71
        step();
        set0(1, 0, 32'd84, '0, '0);
        @(negedge clk);
        check("rd_m0_gnt",   64'(bus.m0_gnt),   64'(1));
        check("rd_mem_we",   64'(bus.mem_we),   64'(0));
        check("rd_mem_addr", 64'(bus.mem_addr), 64'(84));
        step();
        set0(0, 0, '0, '0, '0);
        bus.mem_rdata = 32'd71;
        @(negedge clk);
        check("rd_m0_rvalid", 64'(bus.m0_rvalid), 64'(1));
        check("rd_m0_rdata",  64'(bus.m0_rdata),  64'(71));
        check("rd_m1_rvalid", 64'(bus.m1_rvalid), 64'(0));

        // loader holds lock for 3 grants, then an unlocked grant
        step();
        set1(1, 1, 32'h200, 32'hA5A5, 4'h3, 1);
        @(negedge clk);
        check("lk_m1_gnt0", 64'(bus.m1_gnt), 64'(1));
        check("lk_m0_gnt0", 64'(bus.m0_gnt), 64'(0));
        for (int i = 1; i < 4; i++) begin
            step();
            set0(1, 1, 32'h300, 32'h5A5A, 4'hC);
            if (i == 3) bus.m1_lock = 1'b0;
            @(negedge clk);
            check($sformatf("lk_m1_gnt%0d", i), 64'(bus.m1_gnt), 64'(1));
            check($sformatf("lk_m0_gnt%0d", i), 64'(bus.m0_gnt), 64'(0));
        end
        step();
        set1(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        check("lk_release_m0_gnt", 64'(bus.m0_gnt), 64'(1));

        // abandoned lock
        step();
        set0(0, 0, '0, '0, '0);
        set1(1, 1, 32'h204, 32'h1, 4'h1, 1);
        @(negedge clk);
        check("ab_m1_gnt", 64'(bus.m1_gnt), 64'(1));
        step();
        set1(0, 0, '0, '0, '0, 0);
        set0(1, 1, 32'h304, 32'h2, 4'h2);
        @(negedge clk);
        check("ab_m0_gnt_locked", 64'(bus.m0_gnt), 64'(0));
        step();
        @(negedge clk);
        check("ab_m0_gnt_after", 64'(bus.m0_gnt), 64'(1));

        // port 0 read granted, reset asserted before the next edge
        step();
        set0(1, 0, 32'h44, '0, '0);
        @(negedge clk);
        check("mr_m0_gnt", 64'(bus.m0_gnt), 64'(1));
        #2 reset = 1'b0;
        step();
        @(negedge clk);
        check("mr_m0_rvalid", 64'(bus.m0_rvalid), 64'(0));
        check("mr_m0_gnt",    64'(bus.m0_gnt),    64'(0));
        check("mr_m1_gnt",    64'(bus.m1_gnt),    64'(0));
        step();
        reset = 1'b1;
        set1(1, 0, 32'h48, '0, '0, 0);
        @(negedge clk);
        check("mr_tie_m0_gnt", 64'(bus.m0_gnt), 64'(1));
        check("mr_tie_m1_gnt", 64'(bus.m1_gnt), 64'(0));
        step();
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0, 0);

        // randomized traffic; requests held until granted, occasional cancel/reset
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.mem_rdata = $urandom;
            if (bus.m0_req && exp_g0) bus.m0_req = 1'b0;
            if (bus.m1_req && exp_g1) bus.m1_req = 1'b0;
            if (!bus.m0_req) begin
                if ($urandom_range(0, 3) != 0)
                    set0(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.m0_req = 1'b0;
            end
            if (!bus.m1_req) begin
                if ($urandom_range(0, 2) != 0)
                    set1(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                         1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.m1_req = 1'b0;
            end
            reset = ($urandom_range(0, 199) != 0);
        end
        step();
        reset = 1'b1;
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter sharing the single-port synchronous data memory between the RISC-V core's load/store port (port 0) and the program loader/debug port (port 1). Performs per-cycle round-robin arbitration with an optional bus lock for multi-beat loader transfers. Returns read data one cycle after grant, tagged to the winning port. Sits between the core's `address`/`write_data`/`mem_write_enable` outputs and the data RAM.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width; multiple of 8

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request; held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  byte address
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data
- `m0_wstrb`, `m1_wstrb`  in  DATA_WIDTH/8  byte enables for writes
- `m1_lock`  in  1  loader requests to keep ownership after its current grant
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; transfer occurs when req & gnt
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, one cycle after read grant
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data; equals `mem_rdata` when rvalid is high, else 0
- `mem_en`, `mem_we`  out  1  RAM access enable / write enable
- `mem_addr`  out  ADDR_WIDTH  RAM byte address
- `mem_wdata`  out  DATA_WIDTH  RAM write data
- `mem_wstrb`  out  DATA_WIDTH/8  RAM byte enables
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after `mem_en & !mem_we`

## Operation
- State: `last_owner` (reset = 1, so port 0 wins the first tie), `locked` (reset = 0), `rd_owner_q`/`rd_pending_q` (reset = none/0).
- Arbitration each cycle:
  - `locked` high: only port 1 may be granted; `m0_gnt` = 0.
  - Exactly one request: that port is granted.
  - Both requesting: port opposite `last_owner` is granted.
- Grant updates `last_owner` to the granted port.
- `locked` sets on a port-1 grant with `m1_lock` = 1. It clears on a port-1 grant with `m1_lock` = 0. It also clears in any cycle `locked` is high and `m1_req` is low, so an abandoned lock is released.
- Memory mux: `mem_en` = any grant. The granted port's `we`, `addr`, `wdata` and `wstrb` drive the RAM. With no grant, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0 and `mem_wstrb` = 0.
- Read response: a read grant registers its owner. Next cycle, that owner's rvalid = 1 and its rdata = `mem_rdata`. Writes produce no response.
- Reset mid-operation: all registered state returns to reset values immediately, and any pending rvalid is dropped.
- Outputs during reset: gnt 0, rvalid 0, rdata 0, `mem_en` 0.

## Timing
- Grant is combinational from req and registered state: zero-cycle grant latency.
- Read latency: rvalid exactly 1 cycle after the granting edge. Throughput is 1 access per cycle, back-to-back reads included.
- Requester must hold req, we, addr, wdata and wstrb stable until the cycle gnt is seen. Deasserting req before grant is a legal cancel.
- A port-0 write under contention waits at most 1 cycle without lock. With lock held, port 0 waits until the lock is released.

## Configuration
- `DATA_MEM_ARB_FIXED_PRIO_EN` defined: round-robin is replaced by fixed priority, port 0 always winning ties. `last_owner` is not implemented, but lock behaviour is kept.
- Not defined: round-robin as above.

## Structure
- Package `data_mem_arb_pkg`:
  - owner typedef (`OWNER_CORE` = 0, `OWNER_LOADER` = 1)
  - default width constants
- Sub-module `arb_rr2`: 2-way round-robin/fixed-priority grant logic with the `last_owner` register and lock input.
- Top level holds the mux, the read-response pipeline register and rdata steering.

## Test plan
- Port 0 only: write addr 84, data 71, strb 0xF. Expect:
  - same cycle: `m0_gnt` = 1, `mem_we` = 1, `mem_addr` = 84, `mem_wdata` = 71
  - no `m0_rvalid` follows.
- Port 0 reads addr 84 with RAM returning 71. Expect `m0_rvalid` = 1 and `m0_rdata` = 71 on the next cycle, with `m1_rvalid` = 0.
- Both ports request continuously for 4 cycles after reset. Grants go 0,1,0,1, each rvalid matches its owner. With the macro defined, grants go 0,0,0,0.
- Port 1 with `m1_lock` = 1 for 3 grants while port 0 requests. Expect:
  - `m0_gnt` = 0 for those 3 cycles
  - port 0 granted the cycle after port 1's unlocked grant.
- Lock abandonment: `m1_lock` grant, then `m1_req` drops. Expect `locked` cleared and port 0 granted within 2 cycles.
- Port 0 read granted, then `reset` driven low before the next edge. Expect no `m0_rvalid`, all gnt 0, and port 0 winning the first tie after release.
